ascon_encrypt_fsm: RTL and testbench

Control state machine for Ascon-128 authenticated encryption. It drives the control inputs of `permutator_xor` and of the double-init round counter (`counter_double_init`), a job that benches currently do by hand. It sequences initialisation (p12), associated-data absorption (p6), plaintext encryption (p6) and finalisation (p12), and handshakes 64-bit data blocks with the upstream source. The block is purely control; all state and data live in the datapath.

---
 rtl/ascon_encrypt_fsm_if.sv | 47 ++++
 rtl/ascon_encrypt_fsm.sv | 242 ++++++++++++++++++++++++
 tb/tb_ascon_encrypt_fsm.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_encrypt_fsm_if.sv
// ============================================================================
// Module   : ascon_encrypt_fsm_if
// Purpose  : Control bundle between the Ascon-128 encryption sequencer and
//            its surroundings (upstream block source, permutator_xor and the
//            double-init round counter).
// Modports : master - the sequencer (drives control, reads start/round/valid)
//            slave  - the environment (drives start/round/valid, reads control)
// Signals  : start_i, round_i[3:0], data_valid_i      (toward the sequencer)
//            data_ready_o, input_select_o, xorup_select_o, xordn_select_o[1:0],
//            final_o, ena_reg_o, ena_rnd_o, init_a_o, init_b_o,
//            cipher_valid_o, end_o                    (from the sequencer)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_encrypt_fsm_if;
  logic       start_i;
  logic [3:0] round_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic       input_select_o;
  logic       xorup_select_o;
  logic [1:0] xordn_select_o;
  logic       final_o;
  logic       ena_reg_o;
  logic       ena_rnd_o;
  logic       init_a_o;
  logic       init_b_o;
  logic       cipher_valid_o;
  logic       end_o;

  modport master (
    input  start_i, round_i, data_valid_i,
    output data_ready_o, input_select_o, xorup_select_o, xordn_select_o,
           final_o, ena_reg_o, ena_rnd_o, init_a_o, init_b_o,
           cipher_valid_o, end_o
  );

  modport slave (
    output start_i, round_i, data_valid_i,
    input  data_ready_o, input_select_o, xorup_select_o, xordn_select_o,
           final_o, ena_reg_o, ena_rnd_o, init_a_o, init_b_o,
           cipher_valid_o, end_o
  );
endinterface

`default_nettype wire

// File: rtl/ascon_encrypt_fsm.sv
// ============================================================================
// Module   : ascon_encrypt_fsm
// Purpose  : Control sequencer for Ascon-128 authenticated encryption.
//            Runs p12 initialisation, one p6 per associated-data block, one p6
//            per non-final plaintext block and a p12 finalisation, and
//            handshakes 64-bit blocks with the upstream source. Pure control:
//            state and data live in the permutator datapath.
// Params   : NB_AD - number of 64-bit associated-data blocks (>= 1)
//            NB_PT - number of 64-bit plaintext blocks (>= 1)
// Ports    : clock_i  - clock
//            resetb_i - synchronous active-low reset
//            bus      - ascon_encrypt_fsm_if.master control bundle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_encrypt_fsm #(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  wire logic           clock_i,
  input  wire logic           resetb_i,
  ascon_encrypt_fsm_if.master bus
);

  localparam int c_MAX_BLK = (NB_AD > NB_PT) ? NB_AD : NB_PT;
  localparam int c_CNT_W   = (c_MAX_BLK > 1) ? $clog2(c_MAX_BLK) : 1;

  // Block indices are zero-based, so "last" is NB-1. c_PEN_PT is the index
  // of the block just before the final plaintext block; it only matters when
  // NB_PT >= 2 (PT_RND is never entered otherwise).
  localparam logic [c_CNT_W-1:0] c_LAST_AD = c_CNT_W'(NB_AD - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_PT = c_CNT_W'(NB_PT - 1);
  localparam logic [c_CNT_W-1:0] c_PEN_PT  = c_CNT_W'(NB_PT - 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [3:0]         c_LAST_RND = 4'd11;

  localparam logic [1:0] c_XDN_NONE = 2'b00;
  localparam logic [1:0] c_XDN_KEY  = 2'b01;
  localparam logic [1:0] c_XDN_DSEP = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_INIT_RND = 4'd2,
    S_WAIT_AD  = 4'd3,
    S_AD_RND   = 4'd4,
    S_WAIT_PT  = 4'd5,
    S_PT_RND   = 4'd6,
    S_FIN_RND  = 4'd7,
    S_END      = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_CNT_W-1:0] r_blk_cnt;
  logic               w_cnt_clr;
  logic               w_cnt_inc;

  logic       w_data_ready;
  logic       w_input_select;
  logic       w_xorup_select;
  logic [1:0] w_xordn_select;
  logic       w_final;
  logic       w_ena_reg;
  logic       w_ena_rnd;
  logic       w_init_a;
  logic       w_init_b;
  logic       w_cipher_valid;
  logic       w_end;

  logic w_round_last;
  logic w_last_ad;
  logic w_last_pt;
  logic w_pen_pt;

  assign w_round_last = (bus.round_i == c_LAST_RND);
  assign w_last_ad    = (r_blk_cnt == c_LAST_AD);
  assign w_last_pt    = (r_blk_cnt == c_LAST_PT);
  assign w_pen_pt     = (r_blk_cnt == c_PEN_PT);

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_state   <= S_IDLE;
      r_blk_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_cnt_clr) begin
        r_blk_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_blk_cnt <= r_blk_cnt + c_CNT_ONE;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_cnt_clr      = 1'b0;
    w_cnt_inc      = 1'b0;
    w_data_ready   = 1'b0;
    w_input_select = 1'b0;
    w_xorup_select = 1'b0;
    w_xordn_select = c_XDN_NONE;
    w_final        = 1'b0;
    w_ena_reg      = 1'b0;
    w_ena_rnd      = 1'b0;
    w_init_a       = 1'b0;
    w_init_b       = 1'b0;
    w_cipher_valid = 1'b0;
    w_end          = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Keep the round counter parked at 0 so INIT starts on round 0.
        w_init_a = 1'b1;
        if (bus.start_i) begin
          w_cnt_clr    = 1'b1;
          w_next_state = S_INIT;
        end
      end

      S_INIT: begin
        w_ena_reg    = 1'b1;
        w_ena_rnd    = 1'b1;
        w_next_state = S_INIT_RND;
      end

      S_INIT_RND: begin
        w_input_select = 1'b1;
        w_ena_reg      = 1'b1;
        w_ena_rnd      = 1'b1;
        if (w_round_last) begin
          w_xordn_select = c_XDN_KEY;
          w_init_b       = 1'b1;
          w_next_state   = S_WAIT_AD;
        end
      end

      S_WAIT_AD: begin
        // Ready is unconditional here, so a transfer is simply data_valid_i.
        w_data_ready = 1'b1;
        if (bus.data_valid_i) begin
          w_xorup_select = 1'b1;
          w_ena_reg      = 1'b1;
          w_ena_rnd      = 1'b1;
          w_next_state   = S_AD_RND;
        end else begin
          w_init_b = 1'b1;
        end
      end

      S_AD_RND: begin
        w_input_select = 1'b1;
        w_ena_reg      = 1'b1;
        w_ena_rnd      = 1'b1;
        if (w_round_last) begin
          if (!w_last_ad) begin
            w_init_b     = 1'b1;
            w_cnt_inc    = 1'b1;
            w_next_state = S_WAIT_AD;
          end else begin
            // Leaving AD: domain separation, restart the block index for PT.
            // A single PT block is also the final one, which runs p12.
            w_xordn_select = c_XDN_DSEP;
            w_init_a       = (c_LAST_PT == '0);
            w_init_b       = (c_LAST_PT != '0);
            w_cnt_clr      = 1'b1;
            w_next_state   = S_WAIT_PT;
          end
        end
      end

      S_WAIT_PT: begin
        w_data_ready = 1'b1;
        if (bus.data_valid_i) begin
          w_xorup_select = 1'b1;
          w_cipher_valid = 1'b1;
          w_ena_reg      = 1'b1;
          w_ena_rnd      = 1'b1;
          if (w_last_pt) begin
            w_final      = 1'b1;
            w_next_state = S_FIN_RND;
          end else begin
            w_next_state = S_PT_RND;
          end
        end else begin
          w_init_a = w_last_pt;
          w_init_b = !w_last_pt;
        end
      end

      S_PT_RND: begin
        w_input_select = 1'b1;
        w_ena_reg      = 1'b1;
        w_ena_rnd      = 1'b1;
        if (w_round_last) begin
          // The preload targets the upcoming block, hence the "penultimate" test.
          w_init_a     = w_pen_pt;
          w_init_b     = !w_pen_pt;
          w_cnt_inc    = 1'b1;
          w_next_state = S_WAIT_PT;
        end
      end

      S_FIN_RND: begin
        w_input_select = 1'b1;
        w_ena_reg      = 1'b1;
        w_ena_rnd      = 1'b1;
        if (w_round_last) begin
          w_xordn_select = c_XDN_KEY;
          w_next_state   = S_END;
        end
      end

      S_END: begin
        w_end        = 1'b1;
        w_init_a     = 1'b1;
        w_next_state = S_IDLE;
      end

      default: begin
        w_init_a     = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign bus.data_ready_o   = w_data_ready;
  assign bus.input_select_o = w_input_select;
  assign bus.xorup_select_o = w_xorup_select;
  assign bus.xordn_select_o = w_xordn_select;
  assign bus.final_o        = w_final;
  assign bus.ena_reg_o      = w_ena_reg;
  assign bus.ena_rnd_o      = w_ena_rnd;
  assign bus.init_a_o       = w_init_a;
  assign bus.init_b_o       = w_init_b;
  assign bus.cipher_valid_o = w_cipher_valid;
  assign bus.end_o          = w_end;

endmodule

`default_nettype wire

// File: tb/tb_ascon_encrypt_fsm.sv
// ============================================================================
// Module   : tb_ascon_encrypt_fsm
// Purpose  : Self-checking bench for ascon_encrypt_fsm. Three instances
//            (NB_AD/NB_PT = 1/4, 1/1, 3/2) each close the loop through a model
//            of the double-init round counter. The expected output trace of a
//            whole job is built up front as a list of phases (init rounds,
//            per-block waits and rounds, finalisation), with random stall
//            lengths and random ignored inputs, then compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_encrypt_fsm;

  // Output vector layout:
  // [11] ready [10] input_sel [9] xorup [8:7] xordn [6] final [5] ena_reg
  // [4] ena_rnd [3] init_a [2] init_b [1] cipher_valid [0] end
  localparam logic [11:0] RDY   = 12'h800;
  localparam logic [11:0] ISEL  = 12'h400;
  localparam logic [11:0] XUP   = 12'h200;
  localparam logic [11:0] XDN_D = 12'h100;
  localparam logic [11:0] XDN_K = 12'h080;
  localparam logic [11:0] FIN   = 12'h040;
  localparam logic [11:0] EREG  = 12'h020;
  localparam logic [11:0] ERND  = 12'h010;
  localparam logic [11:0] IA    = 12'h008;
  localparam logic [11:0] IB    = 12'h004;
  localparam logic [11:0] CV    = 12'h002;
  localparam logic [11:0] ENDP  = 12'h001;
  localparam logic [11:0] RND   = ISEL | EREG | ERND;

  logic       clk = 1'b0;
  logic       resetb;
  logic [2:0] start_v;
  logic [2:0] dv_v;
  logic [11:0] obs [3];
  logic [3:0]  rnd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_encrypt_fsm_if bus0 ();
  ascon_encrypt_fsm_if bus1 ();
  ascon_encrypt_fsm_if bus2 ();

  ascon_encrypt_fsm #(.NB_AD(1), .NB_PT(4)) u_dut_nom (
    .clock_i (clk), .resetb_i (resetb), .bus (bus0.master));
  ascon_encrypt_fsm #(.NB_AD(1), .NB_PT(1)) u_dut_one (
    .clock_i (clk), .resetb_i (resetb), .bus (bus1.master));
  ascon_encrypt_fsm #(.NB_AD(3), .NB_PT(2)) u_dut_multi (
    .clock_i (clk), .resetb_i (resetb), .bus (bus2.master));

  assign bus0.start_i = start_v[0];  assign bus0.data_valid_i = dv_v[0];  assign bus0.round_i = rnd[0];
  assign bus1.start_i = start_v[1];  assign bus1.data_valid_i = dv_v[1];  assign bus1.round_i = rnd[1];
  assign bus2.start_i = start_v[2];  assign bus2.data_valid_i = dv_v[2];  assign bus2.round_i = rnd[2];

  assign obs[0] = {bus0.data_ready_o, bus0.input_select_o, bus0.xorup_select_o, bus0.xordn_select_o,
                   bus0.final_o, bus0.ena_reg_o, bus0.ena_rnd_o, bus0.init_a_o, bus0.init_b_o,
                   bus0.cipher_valid_o, bus0.end_o};
  assign obs[1] = {bus1.data_ready_o, bus1.input_select_o, bus1.xorup_select_o, bus1.xordn_select_o,
                   bus1.final_o, bus1.ena_reg_o, bus1.ena_rnd_o, bus1.init_a_o, bus1.init_b_o,
                   bus1.cipher_valid_o, bus1.end_o};
  assign obs[2] = {bus2.data_ready_o, bus2.input_select_o, bus2.xorup_select_o, bus2.xordn_select_o,
                   bus2.final_o, bus2.ena_reg_o, bus2.ena_rnd_o, bus2.init_a_o, bus2.init_b_o,
                   bus2.cipher_valid_o, bus2.end_o};

  // Double-init round counter: preload 0 (init_a), preload 6 (init_b), else count.
  function automatic logic [3:0] next_round(logic [3:0] cur, logic [11:0] o);
    if (o[3]) return 4'd0;
    if (o[2]) return 4'd6;
    if (o[4]) return cur + 4'd1;
    return cur;
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rnd[k] <= !resetb ? 4'd0 : next_round(rnd[k], obs[k]);
    end
  end

  // Expected job trace
  logic [11:0] exp_q [$];
  logic [3:0]  erd_q [$];
  bit          dv_q  [$];
  bit          st_q  [$];
  int          mark_idx;
  bit          noisy;

  function automatic bit nz();
    return noisy ? bit'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic push(logic [11:0] e, logic [3:0] r, bit dv, bit st);
    exp_q.push_back(e);
    erd_q.push_back(r);
    dv_q.push_back(dv);
    st_q.push_back(st);
  endtask

  task automatic build(int nad, int npt, int smin, int smax, bit nois);
    logic [11:0] e;
    int          s;
    bit          last;
    exp_q.delete(); erd_q.delete(); dv_q.delete(); st_q.delete();
    noisy    = nois;
    mark_idx = -1;
    push(IA, 4'd0, nz(), 1'b1);                       // idle, start sampled
    push(EREG | ERND, 4'd0, nz(), nz());              // round 0 on loaded state
    for (int r = 1; r <= 11; r++) begin
      e = RND | ((r == 11) ? (XDN_K | IB) : 12'h000);
      push(e, 4'(r), nz(), nz());
    end
    for (int b = 0; b < nad; b++) begin
      s = int'($urandom_range(smin, smax));
      for (int k = 0; k < s; k++) push(RDY | IB, 4'd6, 1'b0, nz());
      push(RDY | XUP | EREG | ERND, 4'd6, 1'b1, nz());
      for (int r = 7; r <= 11; r++) begin
        e = RND;
        if (r == 11) e |= (b < nad - 1) ? IB : (XDN_D | ((npt == 1) ? IA : IB));
        if (b == 0 && r == 8) mark_idx = exp_q.size();
        push(e, 4'(r), nz(), nz());
      end
    end
    for (int p = 0; p < npt; p++) begin
      last = (p == npt - 1);
      s = int'($urandom_range(smin, smax));
      for (int k = 0; k < s; k++) push(RDY | (last ? IA : IB), last ? 4'd0 : 4'd6, 1'b0, nz());
      push(RDY | XUP | CV | EREG | ERND | (last ? FIN : 12'h000), last ? 4'd0 : 4'd6, 1'b1, nz());
      if (!last) begin
        for (int r = 7; r <= 11; r++) begin
          e = RND | ((r == 11) ? ((p + 1 == npt - 1) ? IA : IB) : 12'h000);
          push(e, 4'(r), nz(), nz());
        end
      end else begin
        for (int r = 1; r <= 11; r++) begin
          e = RND | ((r == 11) ? XDN_K : 12'h000);
          push(e, 4'(r), nz(), nz());
        end
      end
    end
    push(ENDP | IA, 4'd12, nz(), nz());
    push(IA, 4'd0, 1'b0, 1'b0);
    push(IA, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check(string tag, int idx, logic [11:0] got, logic [11:0] expv);
    checks++;
    assert (got === expv)
    else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, got, expv);
    end
  endtask

  // Replays the prepared trace on instance sel. With abort_idx >= 0, reset is
  // asserted during that cycle and the instance must be idle on the next one.
  task automatic run(int sel, string tag, int abort_idx);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      start_v[sel] = st_q[i];
      dv_v[sel]    = dv_q[i];
      if (i == abort_idx) resetb = 1'b0;
      #1;
      check({tag, "_out"}, i, obs[sel], exp_q[i]);
      check({tag, "_rnd"}, i, {8'h00, rnd[sel]}, {8'h00, erd_q[i]});
      if (i == abort_idx) begin
        @(posedge clk);
        #1;
        resetb  = 1'b1;
        start_v = '0;
        dv_v    = '0;
        #1;
        check({tag, "_rst_out"}, i + 1, obs[sel], IA);
        check({tag, "_rst_rnd"}, i + 1, {8'h00, rnd[sel]}, 12'h000);
        break;
      end
    end
    start_v[sel] = 1'b0;
    dv_v[sel]    = 1'b0;
  endtask

  initial begin
    resetb  = 1'b0;
    start_v = '0;
    dv_v    = '0;
    noisy   = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check("reset_out", k, obs[k], IA);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        check("idle_out", c, obs[k], IA);
        check("idle_rnd", c, {8'h00, rnd[k]}, 12'h000);
      end
    end

    build(1, 4, 0, 0, 1'b0);  run(0, "nominal", -1);
    build(1, 4, 0, 0, 1'b1);  run(0, "spurious", -1);
    build(1, 4, 3, 3, 1'b0);  run(0, "stall3", -1);
    build(1, 4, 0, 0, 1'b0);  run(0, "midreset", mark_idx);
    build(1, 4, 0, 0, 1'b0);  run(0, "replay", -1);
    build(1, 1, 0, 0, 1'b0);  run(1, "single", -1);
    build(1, 1, 0, 3, 1'b1);  run(1, "single_rand", -1);
    build(3, 2, 0, 0, 1'b0);  run(2, "multi", -1);
    build(3, 2, 0, 3, 1'b1);  run(2, "multi_rand", -1);
    for (int j = 0; j < 3; j++) begin
      build(1, 4, 0, 4, 1'b1);  run(0, "rand_nom", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
